// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response channels of both clients plus the RAM-side bus.
// slave is the arbiter's view; master is the clients' and RAM's view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wr;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wr;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              ram_ce;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              init_done;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_ce, ram_wr, ram_addr, ram_wdata,
        input  ram_rdata,
        output init_done
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_ce, ram_wr, ram_addr, ram_wdata,
        output ram_rdata,
        input  init_done
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one single-port synchronous RAM between two
// valid/ready clients, with an optional post-reset fill sweep.
module sram_arbiter #(
    parameter int                 ADDR_W     = 6,
    parameter int                 DATA_W     = 8,
    parameter bit                 INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rr;
    logic              grant;
    logic              accept;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_pend, rd_port;
    logic              rsp_v, rsp_port;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        grant     = (bus.req0_valid & bus.req1_valid) ? rr : bus.req1_valid;
        sel_wr    = grant ? bus.req1_wr    : bus.req0_wr;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
        if (state == INIT)
            state_nxt = (&cnt) ? RUN : INIT;
        else
            accept = bus.req0_valid | bus.req1_valid;
    end

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;
    assign bus.init_done  = (state == RUN);
    assign bus.rsp0_valid = rsp_v & ~rsp_port;
    assign bus.rsp1_valid = rsp_v & rsp_port;
    assign bus.rsp0_rdata = bus.ram_rdata;
    assign bus.rsp1_rdata = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= INIT_EN ? INIT : RUN;
            cnt           <= '0;
            rr            <= 1'b0;
            bus.ram_ce    <= 1'b0;
            bus.ram_wr    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            rd_pend       <= 1'b0;
            rd_port       <= 1'b0;
            rsp_v         <= 1'b0;
            rsp_port      <= 1'b0;
        end else begin
            state    <= state_nxt;
            // the RAM registers a read one cycle after issue, so the tag trails by two stages
            rd_pend  <= accept & ~sel_wr;
            rd_port  <= grant;
            rsp_v    <= rd_pend;
            rsp_port <= rd_port;
            if (state == INIT) begin
                bus.ram_ce    <= 1'b1;
                bus.ram_wr    <= 1'b1;
                bus.ram_addr  <= cnt;
                bus.ram_wdata <= INIT_VALUE;
                cnt           <= cnt + 1'b1;
            end else if (accept) begin
                bus.ram_ce    <= 1'b1;
                bus.ram_wr    <= sel_wr;
                bus.ram_addr  <= sel_addr;
                bus.ram_wdata <= sel_wdata;
                rr            <= ~grant;
            end else begin
                bus.ram_ce <= 1'b0;
                bus.ram_wr <= 1'b0;
            end
        end
    end
endmodule
